// File: rtl/cdb_arbiter.sv
// Multi-producer common data bus: round-robin arbitration over valid/ready sources
// into a registered broadcast with stall and flush. Define CDB_STATS_EN for counters.
module cdb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3,
  parameter int REG_AW = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_SRC-1:0]        src_valid,
  input  logic [N_SRC*TAG_W-1:0]  src_tag,
  input  logic [N_SRC*REG_AW-1:0] src_dest,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_ready,
  input  logic                    cdb_stall,
  input  logic                    flush,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [REG_AW-1:0]       cdb_dest,
  output logic [DATA_W-1:0]       cdb_data
`ifdef CDB_STATS_EN
  ,
  output logic [15:0]             stat_bcast,
  output logic [15:0]             stat_conflict
`endif
);

  localparam int PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PTR_W-1:0] rrPtr;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;
  logic [PTR_W-1:0] nextPtr;
  logic             anyValid;
  logic             grantEn;
  logic             transfer;

  // Index addition modulo N_SRC without a divider; both operands are already below N_SRC.
  function automatic logic [PTR_W-1:0] wrapAdd(input logic [PTR_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N_SRC) sum = sum - N_SRC;
    return PTR_W'(sum);
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    anyValid = 1'b0;
    winner   = '0;
    cand     = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = wrapAdd(rrPtr, k);
      if (!anyValid && src_valid[cand]) begin
        anyValid = 1'b1;
        winner   = cand;
      end
    end
  end

  assign nextPtr   = wrapAdd(winner, 1);
  assign grantEn   = ~cdb_stall & ~flush;
  assign transfer  = anyValid & grantEn & reset_n;
  assign src_ready = transfer ? (N_SRC'(1) << winner) : '0;

  // Flush outranks stall: a squashed broadcast must not linger while the consumer is stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      rrPtr     <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_dest  <= '0;
      cdb_data  <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else if (cdb_stall) begin
      cdb_valid <= cdb_valid;
    end else if (transfer) begin
      cdb_valid <= 1'b1;
      cdb_tag   <= src_tag[winner*TAG_W +: TAG_W];
      cdb_dest  <= src_dest[winner*REG_AW +: REG_AW];
      cdb_data  <= src_data[winner*DATA_W +: DATA_W];
      rrPtr     <= nextPtr;
    end else begin
      cdb_valid <= 1'b0;
    end
  end

`ifdef CDB_STATS_EN
  logic multiReq;
  assign multiReq = $countones(src_valid) > 1;

  // Saturating event counters; flush leaves them untouched.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_bcast    <= '0;
      stat_conflict <= '0;
    end else if (transfer) begin
      if (stat_bcast != 16'hFFFF) stat_bcast <= stat_bcast + 16'd1;
      if (multiReq && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a per-cycle reference model of the bus plus directed scenarios
// with hand-computed expectations.
module tb_cdb_arbiter;

  localparam int N = 3;

  logic          clock;
  logic          reset_n;
  logic [N-1:0]  src_valid;
  logic [N*3-1:0]  src_tag;
  logic [N*3-1:0]  src_dest;
  logic [N*16-1:0] src_data;
  logic [N-1:0]  src_ready;
  logic          cdb_stall;
  logic          flush;
  logic          cdb_valid;
  logic [2:0]    cdb_tag;
  logic [2:0]    cdb_dest;
  logic [15:0]   cdb_data;
`ifdef CDB_STATS_EN
  logic [15:0]   stat_bcast;
  logic [15:0]   stat_conflict;
`endif

  cdb_arbiter #(.N_SRC(N), .DATA_W(16), .TAG_W(3), .REG_AW(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .src_valid(src_valid), .src_tag(src_tag), .src_dest(src_dest), .src_data(src_data),
    .src_ready(src_ready), .cdb_stall(cdb_stall), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_dest(cdb_dest), .cdb_data(cdb_data)
`ifdef CDB_STATS_EN
    , .stat_bcast(stat_bcast), .stat_conflict(stat_conflict)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bus as a sequence of accepted results.
  int          mRr    = 0;
  logic        mValid = 1'b0;
  logic [2:0]  mTag   = '0;
  logic [2:0]  mDest  = '0;
  logic [15:0] mData  = '0;
  int          mBcast = 0;
  int          mConf  = 0;

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] expReady();
    int w;
    w = pick(src_valid, mRr);
    if (!reset_n || cdb_stall || flush || w < 0) return '0;
    return N'(1 << w);
  endfunction

  function automatic int popcnt(input logic [N-1:0] v);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(v[i]);
    return c;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mRr <= 0; mValid <= 1'b0; mTag <= '0; mDest <= '0; mData <= '0;
      mBcast <= 0; mConf <= 0;
    end else if (flush) begin
      mValid <= 1'b0;
    end else if (cdb_stall) begin
      mValid <= mValid;
    end else if (pick(src_valid, mRr) >= 0) begin
      mValid <= 1'b1;
      mTag   <= src_tag[pick(src_valid, mRr)*3 +: 3];
      mDest  <= src_dest[pick(src_valid, mRr)*3 +: 3];
      mData  <= src_data[pick(src_valid, mRr)*16 +: 16];
      mRr    <= (pick(src_valid, mRr) + 1) % N;
      mBcast <= (mBcast < 65535) ? mBcast + 1 : mBcast;
      if (popcnt(src_valid) >= 2) mConf <= (mConf < 65535) ? mConf + 1 : mConf;
    end else begin
      mValid <= 1'b0;
    end
  end

  always @(negedge clock) begin
    check("model_ready", 32'(src_ready), 32'(expReady()));
    check("model_valid", 32'(cdb_valid), 32'(mValid));
    check("model_tag",   32'(cdb_tag),   32'(mTag));
    check("model_dest",  32'(cdb_dest),  32'(mDest));
    check("model_data",  32'(cdb_data),  32'(mData));
`ifdef CDB_STATS_EN
    check("model_bcast", 32'(stat_bcast),    32'(mBcast));
    check("model_conf",  32'(stat_conflict), 32'(mConf));
`endif
  end

  task automatic setSrc(input int i, input logic [2:0] tag, input logic [2:0] dest, input logic [15:0] data);
    src_tag[i*3 +: 3]   = tag;
    src_dest[i*3 +: 3]  = dest;
    src_data[i*16 +: 16] = data;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  logic [N-1:0] rrSeq [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
  int miss;
  int maxMiss;

  initial begin
    reset_n = 1'b1; src_valid = '0; src_tag = '0; src_dest = '0; src_data = '0;
    cdb_stall = 1'b0; flush = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_valid", 32'(cdb_valid), 32'd0);
    check("reset_data", 32'(cdb_data), 32'd0);
    check("reset_ready", 32'(src_ready), 32'd0);
    nextCycle();
    reset_n = 1'b1;

    // Single source after reset
    setSrc(1, 3'd2, 3'd5, 16'h1234);
    src_valid = 3'b010;
    @(negedge clock);
    check("single_ready", 32'(src_ready), 32'b010);
    nextCycle();
    src_valid = '0;
    @(negedge clock);
    check("single_valid", 32'(cdb_valid), 32'd1);
    check("single_tag", 32'(cdb_tag), 32'd2);
    check("single_dest", 32'(cdb_dest), 32'd5);
    check("single_data", 32'(cdb_data), 32'h1234);

    // Fresh reset so the pointer starts at zero, then all three contend
    nextCycle();
    reset_n = 1'b0;
    nextCycle();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) setSrc(i, 3'(i + 1), 3'(i + 3), 16'hA000 + 16'(i));
    src_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check("rr_grant", 32'(src_ready), 32'(rrSeq[k]));
      nextCycle();
    end
    src_valid = '0;
    @(negedge clock);
    check("rr_last_valid", 32'(cdb_valid), 32'd1);
    check("rr_last_tag", 32'(cdb_tag), 32'd3);
`ifdef CDB_STATS_EN
    check("stat_bcast6", 32'(stat_bcast), 32'd6);
    check("stat_conf6", 32'(stat_conflict), 32'd6);
`endif

    // Stall hold
    nextCycle();
    setSrc(2, 3'd6, 3'd7, 16'hBEEF);
    src_valid = 3'b100;
    nextCycle();
    cdb_stall = 1'b1;
    setSrc(0, 3'd1, 3'd2, 16'h5555);
    src_valid = 3'b001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("stall_data", 32'(cdb_data), 32'hBEEF);
      check("stall_valid", 32'(cdb_valid), 32'd1);
      check("stall_ready", 32'(src_ready), 32'd0);
      nextCycle();
    end
    cdb_stall = 1'b0;
    @(negedge clock);
    check("release_data", 32'(cdb_data), 32'hBEEF);
    check("release_ready", 32'(src_ready), 32'b001);
    nextCycle();

    // Flush: transfer now, flush next cycle
    setSrc(1, 3'd4, 3'd1, 16'h7777);
    src_valid = 3'b010;
    @(negedge clock);
    check("after_stall_data", 32'(cdb_data), 32'h5555);
    check("flush_xfer_ready", 32'(src_ready), 32'b010);
    nextCycle();
    flush = 1'b1;
    src_valid = 3'b101;
    @(negedge clock);
    check("flush_ready", 32'(src_ready), 32'd0);
    check("flush_inflight", 32'(cdb_data), 32'h7777);
    nextCycle();
    flush = 1'b0;
    @(negedge clock);
    check("flush_valid", 32'(cdb_valid), 32'd0);
    check("flush_ptr_kept", 32'(src_ready), 32'b100);
    nextCycle();
    src_valid = '0;

    // Asynchronous reset between edges while broadcasting
    #2;
    check("pre_reset_valid", 32'(cdb_valid), 32'd1);
    check("pre_reset_data", 32'(cdb_data), 32'hBEEF);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(cdb_valid), 32'd0);
    nextCycle();
    reset_n = 1'b1;
    src_valid = 3'b110;
    @(negedge clock);
    check("post_reset_grant", 32'(src_ready), 32'b010);
    nextCycle();

    // Fairness: source 2 steady, sources 0 and 1 toggling
    miss = 0;
    maxMiss = 0;
    for (int t = 0; t < 12; t++) begin
      src_valid = (t % 2 == 0) ? 3'b111 : 3'b100;
      @(negedge clock);
      if (src_ready[2]) miss = 0;
      else miss++;
      if (miss > maxMiss) maxMiss = miss;
      nextCycle();
    end
    src_valid = '0;
    check("fair_window", 32'(maxMiss <= 2), 32'd1);

    repeat (2) nextCycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
